// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch controller.
//   fetch_state_t    : fetch FSM state encoding
//   INST_W, PC_INCR  : instruction width and sequential PC step
//   fetch_next_state : state transition for the normal (non-fault) states
// Optional feature macro: FETCH_CTRL_MISALIGN_TRAP_EN adds the FAULT state.
package fetch_pkg;

    localparam int INST_W  = 32;
    localparam int PC_INCR = 4;

    typedef enum logic [2:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        , ST_FAULT
`endif
    } fetch_state_t;

    // Redirect wins over every other event. A redirect that catches a request
    // in flight (granted now, or still waiting) must drain its response.
    function automatic fetch_state_t fetch_next_state(
        input fetch_state_t st,
        input logic         br,
        input logic         gnt,
        input logic         rvalid,
        input logic         ready
    );
        fetch_state_t nxt;
        nxt = st;
        case (st)
            ST_REQ:   nxt = gnt ? (br ? ST_DRAIN : ST_WAIT) : ST_REQ;
            ST_WAIT:  nxt = br ? (rvalid ? ST_REQ : ST_DRAIN)
                               : (rvalid ? ST_HOLD : ST_WAIT);
            ST_HOLD:  nxt = (br || ready) ? ST_REQ : ST_HOLD;
            ST_DRAIN: nxt = rvalid ? ST_REQ : ST_DRAIN;
            default:  nxt = st;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC selection for the fetch controller.
//   rstn      : low selects RESET_PC
//   advance   : decode accepted the held instruction -> pc + 4
//   br_taken  : redirect to br_pc + br_imm (highest priority after reset)
//   pc_next   : value loaded into pc on the next clock
// With FETCH_CTRL_MISALIGN_TRAP_EN:
//   freeze     : controller is in FAULT, pc holds
//   misaligned : redirect target has nonzero bits [1:0]; pc is not updated
// Without it the target is silently word-aligned.
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            rstn,
    input  logic            advance,
    input  logic            br_taken,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    input  logic            freeze,
    output logic            misaligned,
`endif
    output logic [XLEN-1:0] pc_next
);

    logic [XLEN-1:0] target;

    // Both sums wrap modulo 2^XLEN by construction.
    assign target = br_pc + br_imm;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    assign misaligned = br_taken && (target[1:0] != 2'b00);
`endif

    always_comb begin
        pc_next = pc;
        if (!rstn) begin
            pc_next = RESET_PC;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        end else if (freeze) begin
            pc_next = pc;
        end else if (br_taken) begin
            if (!misaligned) pc_next = target;
`else
        end else if (br_taken) begin
            pc_next = target & ~XLEN'(3);
`endif
        end else if (advance) begin
            pc_next = pc + XLEN'(PC_INCR);
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: handshaked PC / instruction-memory fetch loop.
// One fetch outstanding at a time; the returned word is held for decode
// until accepted, then the PC steps by 4 or is redirected by a taken branch.
// Ports:
//   clk, rstn                 : clock, synchronous active-low reset
//   pc                        : architectural fetch PC
//   imem_req/addr/gnt         : request channel (addr always equals pc)
//   imem_rvalid/rdata         : response channel
//   inst_valid/inst/inst_pc   : held instruction towards decode
//   inst_ready                : decode accepts the held instruction
//   br_taken/br_pc/br_imm     : single-cycle redirect to br_pc + br_imm
//   misalign_fault            : sticky fault (only with macro below)
// Optional feature macro: FETCH_CTRL_MISALIGN_TRAP_EN -- misaligned redirect
// targets trap into a FAULT state instead of being word-aligned.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstn,
    output logic [XLEN-1:0]   pc,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc,
    input  logic              inst_ready,
    input  logic              br_taken,
    input  logic [XLEN-1:0]   br_pc,
    input  logic [XLEN-1:0]   br_imm
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    ,
    output logic              misalign_fault
`endif
);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc_next;
    logic            advance;
    logic            capture;

    assign imem_addr = pc;
    assign advance   = (state == ST_HOLD) && inst_ready;
    // A redirect in the same cycle as the response discards the response.
    assign capture   = (state == ST_WAIT) && imem_rvalid && !br_taken;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    logic in_fault;
    logic misaligned;

    assign in_fault  = (state == ST_FAULT);
    // FAULT is terminal until reset; any late response is simply ignored.
    assign state_nxt = (in_fault || misaligned) ? ST_FAULT
                     : fetch_next_state(state, br_taken, imem_gnt, imem_rvalid, inst_ready);
`else
    assign state_nxt = fetch_next_state(state, br_taken, imem_gnt, imem_rvalid, inst_ready);
`endif

    pc_next_sel #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_next_sel (
        .rstn       (rstn),
        .advance    (advance),
        .br_taken   (br_taken),
        .pc         (pc),
        .br_pc      (br_pc),
        .br_imm     (br_imm),
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        .freeze     (in_fault),
        .misaligned (misaligned),
`endif
        .pc_next    (pc_next)
    );

    // Outputs are registered decodes of the next state, so nothing from
    // inst_ready reaches imem_req combinationally.
    always_ff @(posedge clk) begin
        pc <= pc_next;
        if (!rstn) begin
            state      <= ST_REQ;
            imem_req   <= 1'b1;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
            misalign_fault <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            imem_req   <= (state_nxt == ST_REQ);
            inst_valid <= (state_nxt == ST_HOLD);
            if (capture) begin
                inst    <= imem_rdata;
                inst_pc <= pc;
            end
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
            if (state_nxt == ST_FAULT) misalign_fault <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed bench for fetch_controller with a
// transaction-level reference (expected PC sequence, outstanding-request
// count, instruction word = function of its address) checked every cycle,
// plus literal expectations for the documented scenarios.
`timescale 1ns/1ps
module tb_fetch_controller;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] KEY = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pc, imem_addr, imem_rdata, inst, inst_pc, br_pc, br_imm;
    logic        imem_req, imem_gnt, imem_rvalid, inst_valid, inst_ready, br_taken;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    always #5 clk = ~clk;

    fetch_controller #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .br_taken    (br_taken),
        .br_pc       (br_pc),
        .br_imm      (br_imm)
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        ,
        .misalign_fault (misalign_fault)
`endif
    );

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < 0 || i >= q.size()) return 32'hEEEE_EEEE;
        return q[i];
    endfunction

    // ---------------- memory model ----------------
    int          lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic        nx_rvalid = 1'b0;

    always @(posedge clk) begin
        #1;
        imem_rvalid = nx_rvalid;
        imem_rdata  = nx_rvalid ? mem_word(pend_addr) : 32'hBAD0_BAD0;
    end

    // ---------------- reference model + per-cycle compare ----------------
    logic        m_init = 1'b0, m_post_rst = 1'b0, m_post_br = 1'b0, m_fault = 1'b0;
    logic [31:0] m_pc = '0;
    int          m_out = 0;
    logic        prev_valid = 1'b0, prev_hold = 1'b0;
    logic [31:0] prev_inst = '0, prev_ipc = '0;
    logic        fire;
    logic [31:0] tgt;
    int          rc = 0, fire_cnt = 0, vr_cnt = 0;
    logic [31:0] fire_q[$], vr_rc[$], vr_pc[$];

    always @(negedge clk) begin
        fire = imem_req && imem_gnt;
        if (m_init) begin
            chk("pc", pc, m_pc);
            chk("addr_eq_pc", imem_addr, pc);
            if (imem_req) chk("one_outstanding", 32'(m_out), 32'd0);
            chk("req_and_valid", {31'd0, imem_req && inst_valid}, 32'd0);
            if (inst_valid) begin
                chk("inst_word", inst, mem_word(inst_pc));
                chk("inst_pc_eq_pc", inst_pc, pc);
            end
            if (m_post_rst) begin
                chk("rst_req", {31'd0, imem_req}, 32'd1);
                chk("rst_valid", {31'd0, inst_valid}, 32'd0);
                chk("rst_inst", inst, 32'd0);
                chk("rst_inst_pc", inst_pc, 32'd0);
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
                chk("rst_fault", {31'd0, misalign_fault}, 32'd0);
`endif
            end
            if (m_post_br) chk("drop_on_br", {31'd0, inst_valid}, 32'd0);
            if (prev_hold) begin
                chk("hold_valid", {31'd0, inst_valid}, 32'd1);
                chk("hold_inst", inst, prev_inst);
                chk("hold_inst_pc", inst_pc, prev_ipc);
            end
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
            chk("fault_flag", {31'd0, misalign_fault}, {31'd0, m_fault});
            if (m_fault) begin
                chk("fault_req", {31'd0, imem_req}, 32'd0);
                chk("fault_valid", {31'd0, inst_valid}, 32'd0);
            end
`endif
        end
        // logs for literal checks
        if (rstn) begin
            if (fire) begin fire_q.push_back(imem_addr); fire_cnt++; end
            if (inst_valid && !prev_valid) begin
                vr_rc.push_back(32'(rc)); vr_pc.push_back(inst_pc); vr_cnt++;
            end
        end
        // advance the model over the coming edge
        if (!rstn) begin
            m_init = 1'b1; m_pc = RPC; m_out = 0; m_post_rst = 1'b1;
            m_post_br = 1'b0; m_fault = 1'b0; prev_hold = 1'b0;
            fire_q.delete(); vr_rc.delete(); vr_pc.delete();
            rc = 0;
        end else begin
            m_post_rst = 1'b0;
            if (imem_rvalid && m_out > 0) m_out--;
            if (fire) m_out++;
            m_post_br = br_taken;
            prev_hold = inst_valid && !inst_ready && !br_taken;
            tgt = br_pc + br_imm;
            if (m_fault) begin
                m_pc = m_pc;
            end else if (br_taken) begin
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
                if (tgt[1:0] != 2'b00) m_fault = 1'b1;
                else m_pc = tgt;
`else
                m_pc = {tgt[31:2], 2'b00};
`endif
            end else if (inst_valid && inst_ready) begin
                m_pc = m_pc + 32'd4;
            end
            rc++;
        end
        prev_valid = inst_valid;
        prev_inst  = inst;
        prev_ipc   = inst_pc;
        // memory: schedule response, decide rvalid for the next cycle
        if (fire) begin pend_cnt = lat; pend_addr = imem_addr; end
        nx_rvalid = (pend_cnt == 1);
        if (pend_cnt > 0) pend_cnt--;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_fire(input string nm);
        int n0 = fire_cnt;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (fire_cnt != n0) break;
        end
        chk({nm, "_fire_seen"}, {31'd0, fire_cnt != n0}, 32'd1);
    endtask

    task automatic wait_valid(input string nm);
        for (int k = 0; k < 40; k++) begin
            if (inst_valid) break;
            tick();
        end
        chk({nm, "_valid_seen"}, {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic redirect(input logic [31:0] bpc, input logic [31:0] imm);
        br_taken = 1'b1; br_pc = bpc; br_imm = imm; inst_ready = 1'b1;
        tick();
        br_taken = 1'b0; br_pc = '0; br_imm = '0;
    endtask

    initial begin
        int n0;
        imem_gnt = 1'b1; inst_ready = 1'b1; br_taken = 1'b0; br_pc = '0; br_imm = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        lat = 1;
        tick(3);
        rstn = 1'b1;                       // cycle 0 after reset

        // zero-wait streaming
        tick(9);
        chk("seq_fire0", qget(fire_q, 0), 32'h100);
        chk("seq_fire1", qget(fire_q, 1), 32'h104);
        chk("seq_fire2", qget(fire_q, 2), 32'h108);
        chk("seq_vrise0", qget(vr_rc, 0), 32'd2);
        chk("seq_vrise1", qget(vr_rc, 1), 32'd5);
        chk("seq_vrise2", qget(vr_rc, 2), 32'd8);

        // decode stall for 5 cycles in HOLD
        inst_ready = 1'b0;
        wait_valid("stall");
        chk("stall_inst_pc", inst_pc, 32'h10C);
        chk("stall_inst", inst, 32'hDEAD_BFE3);
        n0 = fire_cnt;
        tick(5);
        chk("stall_still_valid", {31'd0, inst_valid}, 32'd1);
        chk("stall_pc", pc, 32'h10C);
        chk("stall_no_req", 32'(fire_cnt - n0), 32'd0);
        lat = 3;
        inst_ready = 1'b1;
        wait_fire("stall_next");
        chk("stall_next_addr", fire_q[$], 32'h110);

        // redirect while waiting -> response drained
        n0 = vr_cnt;
        redirect(32'h200, 32'hFFFF_FFF8);
        lat = 1;
        chk("brwait_pc", pc, 32'h1F8);
        wait_valid("brwait");
        tick();
        chk("brwait_one_rise", 32'(vr_cnt - n0), 32'd1);
        chk("brwait_vr_pc", vr_pc[$], 32'h1F8);

        // redirect and accept in the same HOLD cycle
        inst_ready = 1'b0;
        wait_valid("brhold");
        redirect(32'h300, 32'h20);
        chk("brhold_pc", pc, 32'h320);
        chk("brhold_drop", {31'd0, inst_valid}, 32'd0);
        wait_fire("brhold_next");
        chk("brhold_fire", fire_q[$], 32'h320);

        // wrap from 0xFFFFFFFC to 0
        inst_ready = 1'b0;
        wait_valid("wrap");
        redirect(32'hFFFF_FFF0, 32'h0C);
        wait_fire("wrap_a");
        chk("wrap_top", fire_q[$], 32'hFFFF_FFFC);
        wait_fire("wrap_b");
        chk("wrap_zero", fire_q[$], 32'h0);

        // misaligned target
        inst_ready = 1'b0;
        wait_valid("mis");
        redirect(32'h10, 32'h2);
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        n0 = fire_cnt;
        tick(6);
        chk("mis_fault", {31'd0, misalign_fault}, 32'd1);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        chk("mis_no_fetch", 32'(fire_cnt - n0), 32'd0);
`else
        wait_fire("mis");
        chk("mis_align_fetch", fire_q[$], 32'h10);
`endif

        // reset while a fetch is outstanding; the late response is ignored
        rstn = 1'b0; tick(); rstn = 1'b1;
        lat = 3;
        wait_fire("rstmid");
        rstn = 1'b0; imem_gnt = 1'b0;
        tick();
        rstn = 1'b1;
        n0 = vr_cnt;
        tick(4);
        chk("rstmid_no_valid", 32'(vr_cnt - n0), 32'd0);
        chk("rstmid_req", {31'd0, imem_req}, 32'd1);
        chk("rstmid_pc", pc, 32'h100);
        lat = 1; imem_gnt = 1'b1;
        wait_valid("rstmid");
        chk("rstmid_inst_pc", inst_pc, 32'h100);
        chk("rstmid_inst", inst, 32'hDEAD_BFEF);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the program counter and the instruction-memory port for the mini CPU. It issues one fetch at a time at the current PC and holds the returned instruction for decode until it is accepted. It then advances the PC by 4, or redirects it to a taken-branch target (branch PC + immediate). It sits between the PC register/adders and the instruction memory, and replaces the free-running PC update with a handshaked fetch loop.

## Interface
- XLEN, 32, address/PC width.
- RESET_PC, 0, PC value loaded on reset.

- clk  in  1  clock; all state changes on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- pc  out  XLEN  architectural fetch PC.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; always equals pc.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid; at most one per granted request, no earlier than the cycle after grant.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  held instruction is valid for decode.
- inst  out  32  held instruction.
- inst_pc  out  XLEN  PC of the held instruction.
- inst_ready  in  1  decode accepts inst this cycle.
- br_taken  in  1  taken-branch redirect; single-cycle pulse.
- br_pc  in  XLEN  PC of the branch instruction.
- br_imm  in  XLEN  sign-extended branch immediate.
- misalign_fault  out  1  sticky misaligned-target fault. Present only with FETCH_CTRL_MISALIGN_TRAP_EN.

## Operation
- One outstanding fetch maximum.
- States: REQ, WAIT, HOLD, DRAIN, and FAULT (FAULT only with the macro).
- REQ:
  - imem_req=1.
  - On imem_gnt, go to WAIT.
- WAIT:
  - On imem_rvalid, capture imem_rdata into inst and pc into inst_pc, then go to HOLD.
- HOLD:
  - inst_valid=1.
  - On inst_ready, pc <= pc+4 and go to REQ.
- DRAIN:
  - Waits for the response to an abandoned request.
  - On imem_rvalid, discard the data and go to REQ.
- Redirect (br_taken=1), from any state, takes priority over every other event in that cycle:
  - pc <= br_pc + br_imm.
  - Held instruction is dropped: inst_valid=0 next cycle, even if inst_ready=1 in the same cycle.
  - Next state from REQ with imem_gnt=1: DRAIN.
  - Next state from WAIT without imem_rvalid: DRAIN.
  - Next state from WAIT with imem_rvalid: REQ; the response is discarded.
  - Next state from DRAIN with imem_rvalid: REQ.
  - Next state from DRAIN without imem_rvalid: DRAIN.
  - All other cases: REQ.
- Arithmetic: pc+4 and br_pc+br_imm are computed modulo 2^XLEN. Wrap from all-ones-minus-3 to 0 is legal.
- inst and inst_pc are held stable while inst_valid=1.

## Timing
- Reset values:
  - pc=RESET_PC, state REQ.
  - imem_req=1 in the first cycle after reset.
  - inst_valid=0, inst=0, inst_pc=0, misalign_fault=0.
- Reset mid-operation abandons any outstanding request. Responses arriving after reset, without a request issued after reset, are ignored.
- With zero-wait memory (gnt in cycle 0, rvalid in cycle 1), inst_valid rises in cycle 2.
- Steady-state throughput with zero-wait memory and inst_ready=1: one instruction per 3 cycles.
- Redirect in cycle t: pc shows the target in t+1. With zero-wait memory, the target instruction is valid at t+3; add one cycle per pending drained response.
- Outputs are registered state decodes; no combinational path from inst_ready to imem_req.

## Configuration
- FETCH_CTRL_MISALIGN_TRAP_EN defined:
  - A redirect target with bits [1:0]≠0 does not update pc.
  - The held instruction is still dropped.
  - Controller enters FAULT: imem_req=0, inst_valid=0, misalign_fault=1, left only by reset.
  - A drained response is still absorbed in FAULT.
- Undefined: target bits [1:0] are forced to 0, there is no FAULT state, and the misalign_fault port is absent.

## Structure
- Package fetch_pkg holds:
  - the state enum;
  - INST_W=32;
  - PC_INCR=4.
- Sub-module pc_next_sel: combinational selection of the next PC (hold, pc+4, branch target, RESET_PC), including the alignment check.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory, inst_ready=1 → fetch addresses 0x100, 0x104, 0x108; inst_valid in cycles 2, 5, 8.
- Hold inst_ready=0 for 5 cycles in HOLD → inst/inst_pc stable, no new imem_req, pc stays put; on accept, next address is pc+4.
- br_taken in WAIT with br_pc=0x200, br_imm=-8 → the pending response is discarded (not presented to decode); next fetch at 0x1F8; no inst_valid carries the stale pc.
- br_taken and inst_ready in the same HOLD cycle → instruction dropped, pc=target, no pc+4 step.
- pc=0xFFFFFFFC accepted → next fetch at 0x0.
- With the macro: br_pc=0x10, br_imm=2 → misalign_fault=1, imem_req=0 until reset. Without the macro: fetch at 0x10.
